// File: rtl/trng_postproc.sv
// trng_postproc: raw-bit synchroniser, repetition-count health test, von Neumann debias, word packer.
// Latency: raw_bit to s_bit 2 cycles; packer full to valid 1 cycle; trng_en 1 cycle after en/alarm.
// Backpressure: one word in the output register plus one in the packer; further VN bits dropped while both are held.
module trng_postproc #(
    parameter int WORD_W     = 8,
    parameter int RCT_CUTOFF = 32,
    parameter int WARMUP     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic              trng_en,
    input  logic              raw_bit,
    output logic [WORD_W-1:0] data,
    output logic              valid,
    input  logic              ready,
    output logic              alarm,
    input  logic              clr_alarm
);
    localparam int WC_W = $clog2(WARMUP + 1);
    localparam int RC_W = $clog2(RCT_CUTOFF + 1);
    localparam int PC_W = $clog2(WORD_W + 1);
    localparam logic [WC_W-1:0] WARM_DONE = WC_W'(WARMUP);
    localparam logic [RC_W-1:0] RCT_TRIP  = RC_W'(RCT_CUTOFF);
    localparam logic [PC_W-1:0] PK_FULL   = PC_W'(WORD_W);

    typedef enum logic {VN_IDLE, VN_HAVE_FIRST} vn_state_t;

    logic              s_meta;
    logic              s_bit;
    logic [WC_W-1:0]   warm_cnt;
    logic [RC_W-1:0]   rct_cnt;
    logic              last_bit;
    vn_state_t         vn_state;
    logic              vn_first;
    logic [WORD_W-1:0] pk_sh;
    logic [PC_W-1:0]   pk_cnt;

    logic active;
    logic sample;
    logic trip;
    logic flush;
    logic vn_emit;
    logic pk_full;
    logic load;
    logic pk_take;

    always_comb begin
        active  = en & ~alarm;
        sample  = active && (warm_cnt == WARM_DONE);
        trip    = !alarm && (rct_cnt == RCT_TRIP);
        // Anything that restarts the pipeline empties warm-up, RCT, pair and packer state.
        flush   = !active || clr_alarm || trip;
        vn_emit = sample && (vn_state == VN_HAVE_FIRST) && (s_bit != vn_first);
        pk_full = (pk_cnt == PK_FULL);
        load    = pk_full && (!valid || ready) && !flush;
        pk_take = vn_emit && (!pk_full || load);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_meta   <= 1'b0;
            s_bit    <= 1'b0;
            trng_en  <= 1'b0;
            alarm    <= 1'b0;
            data     <= '0;
            valid    <= 1'b0;
            warm_cnt <= '0;
            rct_cnt  <= '0;
            last_bit <= 1'b0;
            vn_state <= VN_IDLE;
            vn_first <= 1'b0;
            pk_sh    <= '0;
            pk_cnt   <= '0;
        end else begin
            s_meta  <= raw_bit;
            s_bit   <= s_meta;
            trng_en <= en & ~alarm;

            if (clr_alarm) begin
                alarm <= 1'b0;
            end else if (trip) begin
                alarm <= 1'b1;
            end

            if (trip && !clr_alarm) begin
                valid <= 1'b0;
            end else if (load) begin
                data  <= pk_sh;
                valid <= 1'b1;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end

            if (flush) begin
                warm_cnt <= '0;
                rct_cnt  <= '0;
                last_bit <= 1'b0;
                vn_state <= VN_IDLE;
                vn_first <= 1'b0;
                pk_sh    <= '0;
                pk_cnt   <= '0;
            end else begin
                if (warm_cnt != WARM_DONE) begin
                    warm_cnt <= warm_cnt + WC_W'(1);
                end
                if (sample) begin
                    // rct_cnt == 0 marks "no previous sample since restart".
                    if ((rct_cnt != '0) && (s_bit == last_bit)) begin
                        if (rct_cnt != RCT_TRIP) begin
                            rct_cnt <= rct_cnt + RC_W'(1);
                        end
                    end else begin
                        rct_cnt <= RC_W'(1);
                    end
                    last_bit <= s_bit;
                    case (vn_state)
                        VN_IDLE: begin
                            vn_first <= s_bit;
                            vn_state <= VN_HAVE_FIRST;
                        end
                        default: vn_state <= VN_IDLE;
                    endcase
                end
                if (load) begin
                    pk_cnt <= pk_take ? PC_W'(1) : '0;
                end else if (pk_take) begin
                    pk_cnt <= pk_cnt + PC_W'(1);
                end
                if (pk_take) begin
                    pk_sh <= {vn_first, pk_sh[WORD_W-1:1]};
                end
            end
        end
    end
endmodule

// File: tb/tb_trng_postproc.sv
// Bench for trng_postproc: queue-based reference model checked every cycle,
// plus directed scenarios with literal word sequences and alarm timing.
module tb_trng_postproc;
    localparam int W    = 8;
    localparam int CUT  = 32;
    localparam int WARM = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         trng_en;
    logic         raw_bit;
    logic [W-1:0] data;
    logic         valid;
    logic         ready;
    logic         alarm;
    logic         clr_alarm;

    int total = 0;
    int bad   = 0;

    trng_postproc #(.WORD_W(W), .RCT_CUTOFF(CUT), .WARMUP(WARM)) dut (
        .clk(clk), .rst(rst), .en(en), .trng_en(trng_en), .raw_bit(raw_bit),
        .data(data), .valid(valid), .ready(ready), .alarm(alarm), .clr_alarm(clr_alarm)
    );

    always #5 clk = ~clk;

    // Reference model state
    bit           m_init = 1'b0;
    logic         m_s1, m_s2, m_alarm, m_valid, m_trng_en, m_last, m_first;
    logic [W-1:0] m_data;
    int           m_warm, m_run;
    bit           m_have;
    logic         m_pk[$];
    logic [W-1:0] m_got[$];
    logic [W-1:0] dut_got[$];
    logic         prev_valid;
    logic [W-1:0] prev_data;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] word_of();
        logic [W-1:0] w;
        w = '0;
        for (int i = 0; i < m_pk.size(); i++) w[i] = m_pk[i];
        return w;
    endfunction

    task automatic model_step();
        logic s, act, trip, smp, flush, full, ld;
        if (rst) begin
            m_init = 1'b1; m_s1 = 1'b0; m_s2 = 1'b0; m_alarm = 1'b0; m_valid = 1'b0;
            m_trng_en = 1'b0; m_data = '0; m_warm = 0; m_run = 0; m_last = 1'b0;
            m_have = 1'b0; m_first = 1'b0; m_pk.delete();
            return;
        end
        if (!m_init) return;
        s     = m_s2;
        m_s2  = m_s1;
        m_s1  = raw_bit;
        act   = en && !m_alarm;
        trip  = !m_alarm && (m_run >= CUT);
        smp   = act && (m_warm >= WARM);
        flush = !act || clr_alarm || trip;
        full  = (m_pk.size() == W);
        ld    = full && (!m_valid || ready) && !flush;
        if (m_valid && ready) m_got.push_back(m_data);
        m_trng_en = en && !m_alarm;
        if (trip && !clr_alarm) m_valid = 1'b0;
        else if (ld) begin m_data = word_of(); m_valid = 1'b1; end
        else if (m_valid && ready) m_valid = 1'b0;
        if (clr_alarm) m_alarm = 1'b0;
        else if (trip) m_alarm = 1'b1;
        if (flush) begin
            m_warm = 0; m_run = 0; m_have = 1'b0; m_pk.delete();
        end else begin
            if (m_warm < WARM) m_warm++;
            if (ld) m_pk.delete();
            if (smp) begin
                m_run  = (m_run > 0 && s == m_last) ? ((m_run < CUT) ? m_run + 1 : CUT) : 1;
                m_last = s;
                if (!m_have) begin
                    m_have = 1'b1; m_first = s;
                end else begin
                    m_have = 1'b0;
                    if (s != m_first && m_pk.size() < W) m_pk.push_back(m_first);
                end
            end
        end
    endtask

    // Per-cycle compare, 1 time unit after each rising edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (m_init && !rst && prev_valid === 1'b1 && ready) dut_got.push_back(prev_data);
            model_step();
            if (m_init) begin
                chk("cyc valid", valid, m_valid);
                chk("cyc data", data, m_data);
                chk("cyc alarm", alarm, m_alarm);
                chk("cyc trng_en", trng_en, m_trng_en);
            end
            prev_valid = valid;
            prev_data  = data;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #3;
    endtask

    // The sample taken on the first post-warm-up cycle sees pat[0].
    task automatic run_pat(input logic [15:0] pat, input int len, input int start, input int n);
        logic [15:0] p;
        p = pat;
        for (int j = start; j < start + n; j++) begin
            raw_bit = p[(j + 2 * len - 2) % len];
            cyc();
        end
    endtask

    task automatic restart();
        en = 1'b0;
        cyc();
        en = 1'b1;
    endtask

    task automatic chk_words(input string nm, input int n, input logic [W-1:0] w0,
                             input logic [W-1:0] w1, input logic [W-1:0] w2);
        logic [W-1:0] e[3];
        e = '{w0, w1, w2};
        chk({nm, " count"}, dut_got.size(), n);
        chk({nm, " model count"}, m_got.size(), n);
        for (int i = 0; i < n && i < dut_got.size(); i++) chk({nm, " word"}, dut_got[i], e[i]);
        for (int i = 0; i < n && i < m_got.size(); i++) chk({nm, " model word"}, m_got[i], e[i]);
        dut_got.delete();
        m_got.delete();
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; ready = 1'b1; clr_alarm = 1'b0; raw_bit = 1'b0;
        repeat (3) cyc();
        chk("rst valid", valid, 0);
        chk("rst data", data, 0);
        chk("rst alarm", alarm, 0);
        chk("rst trng_en", trng_en, 0);

        // 0,1 stream
        rst = 1'b0; en = 1'b1;
        run_pat(16'h0002, 2, 0, 60);
        chk("t1 alarm", alarm, 0);
        chk_words("t1 01", 3, 8'h00, 8'h00, 8'h00);

        // 1,0 stream
        restart();
        run_pat(16'h0001, 2, 0, 40);
        chk_words("t2 10", 2, 8'hFF, 8'hFF, 8'h00);

        // alternating 01,10 pairs
        restart();
        run_pat(16'h0006, 4, 0, 40);
        chk_words("t3 0110", 2, 8'hAA, 8'hAA, 8'h00);

        // stuck at 1 with a held word in the output register
        ready = 1'b0;
        restart();
        run_pat(16'h0002, 2, 0, 22);
        run_pat(16'h0001, 1, 22, 33);
        chk("t4 pre alarm", alarm, 0);
        chk("t4 pre valid", valid, 1);
        run_pat(16'h0001, 1, 55, 1);
        chk("t4 trip alarm", alarm, 1);
        chk("t4 trip valid", valid, 0);
        chk("t4 trip trng_en", trng_en, 1);
        run_pat(16'h0001, 1, 56, 1);
        chk("t4 trng_en off", trng_en, 0);
        chk_words("t4 stuck", 0, 8'h00, 8'h00, 8'h00);

        // clear alarm and restart with 0,1 stream
        ready = 1'b1; clr_alarm = 1'b1;
        cyc();
        clr_alarm = 1'b0;
        chk("t5 alarm clr", alarm, 0);
        run_pat(16'h0002, 2, 0, 40);
        chk_words("t5 after clr", 2, 8'h00, 8'h00, 8'h00);

        // backpressure: three words' worth of bits with ready low
        ready = 1'b0;
        restart();
        for (int j = 0; j < 66; j++) begin
            raw_bit = (j < 18) ? 1'(j % 2) : (j < 34) ? 1'(1 - j % 2) :
                      (j < 50) ? 1'(j % 2) : 1'(((j - 50) % 4) >= 2);
            ready = (j >= 56);
            cyc();
            if (j == 55) begin
                chk("t6 held valid", valid, 1);
                chk("t6 held data", data, 8'h00);
            end
        end
        chk("t6 drained", valid, 0);
        chk_words("t6 bp", 2, 8'h00, 8'hFF, 8'h00);

        // en dropped after 5 VN bits of a second word
        ready = 1'b0;
        restart();
        for (int j = 0; j < 30; j++) begin
            raw_bit = (j < 18) ? 1'(j % 2) : 1'(1 - j % 2);
            cyc();
        end
        en = 1'b0; raw_bit = 1'b0;
        repeat (3) cyc();
        chk("t7 hold valid", valid, 1);
        chk("t7 hold data", data, 8'h00);
        chk("t7 trng_en", trng_en, 0);
        en = 1'b1;
        run_pat(16'h0002, 2, 0, 22);
        ready = 1'b1;
        run_pat(16'h0002, 2, 22, 15);
        chk_words("t7 en drop", 2, 8'h00, 8'h00, 8'h00);

        // reset with a held word and 3 packed bits
        ready = 1'b0;
        restart();
        run_pat(16'h0002, 2, 0, 26);
        chk("t8 pre valid", valid, 1);
        rst = 1'b1;
        cyc();
        chk("t8 rst valid", valid, 0);
        chk("t8 rst data", data, 0);
        chk("t8 rst alarm", alarm, 0);
        chk("t8 rst trng_en", trng_en, 0);
        rst = 1'b0; ready = 1'b1;
        run_pat(16'h0001, 2, 0, 20);
        chk("t8 no word yet", valid, 0);
        run_pat(16'h0001, 2, 20, 1);
        chk("t8 word valid", valid, 1);
        chk("t8 word data", data, 8'hFF);
        run_pat(16'h0001, 2, 21, 2);
        chk_words("t8 after rst", 1, 8'hFF, 8'h00, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
